// File: rtl/ps2_pkg.sv
// ps2_pkg: parser states, Set-2 protocol byte constants and prefix helper
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, PAUSE} state_t;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_OVR0   = 8'h00;
  localparam logic [7:0] PS2_OVR1   = 8'hFF;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;
  function automatic logic is_prefix(input logic [7:0] b);
    return b == PS2_EXT || b == PS2_BRK || b == PS2_PAUSE;
  endfunction
endpackage

// File: rtl/ps2_key_slot.sv
// ps2_key_slot: held bit and press/release edge pulses for one tracked key
module ps2_key_slot (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       ev_valid,
  input  logic       ev_make,
  input  logic       clr,
  input  logic [8:0] ev_code,
  input  logic [8:0] key_code,
  output logic       held,
  output logic       press,
  output logic       released
);
  logic held_n;
  assign held_n = clr ? 1'b0 : (ev_valid && ev_code == key_code) ? ev_make : held;
  always_ff @(posedge CLOCK_50)
    if (!resetn) begin
      held     <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      held     <= held_n;
      press    <= held_n & ~held;
      released <= held & ~held_n;
    end
endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: Set-2 scancode parser tracking held keys; PS2_PREFIX_TIMEOUT_EN adds a prefix timeout
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {9'h172, 9'h175, 9'h01B, 9'h01D},
  parameter int                    TIMEOUT_CYCLES = 150000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [7:0]          last_byte,
  output logic                protocol_error
);
  state_t     state, state_n;
  logic [2:0] skip;
  logic       ev_valid, ev_make, ev_ext, ovr, err, timeout, pfx;
  assign pfx = is_prefix(received_data);
  always_comb begin
    state_n  = state;
    ev_valid = 1'b0;
    ev_make  = 1'b1;
    ev_ext   = 1'b0;
    ovr      = 1'b0;
    err      = 1'b0;
    if (received_data_en)
      unique case (state)
        IDLE:
          if (received_data == PS2_EXT) state_n = EXT;
          else if (received_data == PS2_BRK) state_n = BRK;
          else if (received_data == PS2_PAUSE) state_n = PAUSE;
          else if (received_data == PS2_OVR0 || received_data == PS2_OVR1) begin
            ovr = 1'b1;
            err = 1'b1;
          end else
            ev_valid = !(received_data == PS2_BAT || received_data == PS2_ACK || received_data == PS2_RESEND);
        EXT:
          if (received_data == PS2_BRK) state_n = EXTBRK;
          else begin
            state_n  = IDLE;
            err      = pfx;
            ev_valid = !pfx;
            ev_ext   = 1'b1;
          end
        BRK, EXTBRK: begin
          state_n  = IDLE;
          err      = pfx;
          ev_valid = !pfx;
          ev_make  = 1'b0;
          ev_ext   = state == EXTBRK;
        end
        PAUSE: state_n = skip == 3'd1 ? IDLE : PAUSE;
        default: state_n = IDLE;
      endcase
    if (timeout) begin
      state_n = IDLE;
      err     = 1'b1;
    end
  end
  always_ff @(posedge CLOCK_50)
    if (!resetn) begin
      state          <= IDLE;
      skip           <= '0;
      last_byte      <= '0;
      protocol_error <= 1'b0;
    end else begin
      state          <= state_n;
      protocol_error <= err;
      if (received_data_en) last_byte <= received_data;
      if (received_data_en && state == IDLE && received_data == PS2_PAUSE) skip <= PAUSE_SKIP;
      else if (received_data_en && state == PAUSE) skip <= skip - 3'd1;
    end
`ifdef PS2_PREFIX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign timeout = state != IDLE && !received_data_en && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge CLOCK_50)
    if (!resetn || received_data_en || state_n == IDLE) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_slot
    ps2_key_slot u_slot (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .ev_valid (ev_valid),
      .ev_make  (ev_make),
      .clr      (ovr),
      .ev_code  ({ev_ext, received_data}),
      .key_code (KEY_CODES[9*i +: 9]),
      .held     (key_held[i]),
      .press    (key_press[i]),
      .released (key_release[i])
    );
  end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: randomized sequence-level scoreboard bench for ps2_key_tracker
module tb_ps2_key_tracker;
  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] received_data = '0;
  logic       received_data_en = 1'b0;
  logic [3:0] key_held, key_press, key_release;
  logic [7:0] last_byte;
  logic       protocol_error;

  ps2_key_tracker dut (
    .CLOCK_50         (CLOCK_50),
    .resetn           (resetn),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .key_held         (key_held),
    .key_press        (key_press),
    .key_release      (key_release),
    .last_byte        (last_byte),
    .protocol_error   (protocol_error)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [3:0] held, press, rel;
    logic       err;
    logic [7:0] lb;
  } exp_t;

  localparam logic [8:0] KC [4] = '{9'h01D, 9'h01B, 9'h175, 9'h172};
  localparam logic [8:0] POOL [8] = '{9'h01D, 9'h01B, 9'h175, 9'h172, 9'h075, 9'h072, 9'h01C, 9'h114};

  exp_t       q[$];
  exp_t       e;
  logic [3:0] m_held = '0, cur_held = '0;
  logic       en_q = 1'b0, rst_q = 1'b0, fin = 1'b0, tmo_ok = 1'b0, tmo_done = 1'b0;
  int         checks = 0, errs = 0, tmo_seen = 0;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge CLOCK_50) begin
    en_q  <= received_data_en & resetn;
    rst_q <= ~resetn;
  end

  always @(negedge CLOCK_50) begin
    if (rst_q) begin
      check("reset_outputs", 32'({key_held, key_press, key_release, protocol_error, last_byte}), 32'd0);
      cur_held = '0;
    end else if (en_q) begin
      check("sb_depth", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("key_held", 32'(key_held), 32'(e.held));
        check("key_press", 32'(key_press), 32'(e.press));
        check("key_release", 32'(key_release), 32'(e.rel));
        check("protocol_error", 32'(protocol_error), 32'(e.err));
        check("last_byte", 32'(last_byte), 32'(e.lb));
        cur_held = e.held;
      end
    end else begin
      if (tmo_ok && protocol_error) tmo_seen++;
      check("idle_held", 32'(key_held), 32'(cur_held));
      check("idle_pulses", 32'({key_press, key_release, protocol_error & ~tmo_ok}), 32'd0);
    end
    if (tmo_done) check("timeout_pulses", 32'(tmo_seen), 32'd1);
    if (fin) check("sb_leftover", 32'(q.size()), 32'd0);
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic [3:0] nh, input logic er);
    exp_t x;
    x.held  = nh;
    x.press = nh & ~m_held;
    x.rel   = m_held & ~nh;
    x.err   = er;
    x.lb    = b;
    q.push_back(x);
    m_held = nh;
    received_data    = b;
    received_data_en = 1'b1;
    tick();
    received_data_en = 1'b0;
    received_data    = 8'($urandom);
    if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
  endtask

  function automatic logic [3:0] apply(input logic [8:0] code, input logic mk);
    logic [3:0] nh = m_held;
    for (int i = 0; i < 4; i++) if (KC[i] == code) nh[i] = mk;
    return nh;
  endfunction

  task automatic seq_key(input logic [8:0] code, input logic mk);
    if (code[8]) send(8'hE0, m_held, 1'b0);
    if (!mk) send(8'hF0, m_held, 1'b0);
    send(code[7:0], apply(code, mk), 1'b0);
  endtask

  task automatic seq_pause();
    logic [7:0] p [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send(p[i], m_held, 1'b0);
  endtask

  task automatic seq_err(input int k);
    case (k)
      0: begin send(8'hF0, m_held, 1'b0); send(8'hE0, m_held, 1'b1); end
      1: begin send(8'hE0, m_held, 1'b0); send(8'hE0, m_held, 1'b1); end
      2: begin send(8'hE0, m_held, 1'b0); send(8'hE1, m_held, 1'b1); end
      3: begin send(8'hF0, m_held, 1'b0); send(8'hF0, m_held, 1'b1); end
      4: begin send(8'hE0, m_held, 1'b0); send(8'hF0, m_held, 1'b0); send(8'hE1, m_held, 1'b1); end
      default: begin send(8'hF0, m_held, 1'b0); send(8'hE1, m_held, 1'b1); end
    endcase
  endtask

  task automatic do_reset();
    repeat (3) tick();
    resetn           = 1'b0;
    received_data    = 8'h5A;
    received_data_en = 1'b1;
    tick();
    received_data_en = 1'b0;
    tick();
    resetn = 1'b1;
    m_held = '0;
    tick();
  endtask

  initial begin
    logic [7:0] ign [3] = '{8'hAA, 8'hFA, 8'hFE};
    do_reset();
    seq_key(9'h01D, 1'b1);
    seq_key(9'h01D, 1'b1);
    seq_key(9'h01D, 1'b0);
    seq_key(9'h175, 1'b1);
    seq_key(9'h175, 1'b0);
    seq_key(9'h075, 1'b1);
    seq_key(9'h01D, 1'b1);
    seq_key(9'h172, 1'b1);
    seq_key(9'h01D, 1'b0);
    seq_pause();
    seq_key(9'h01B, 1'b1);
    send(8'h00, 4'h0, 1'b1);
    seq_err(0);
    send(8'hE0, m_held, 1'b0);
    send(8'hF0, m_held, 1'b0);
    do_reset();
    seq_key(9'h01D, 1'b1);
    for (int n = 0; n < 250; n++) begin
      int r = $urandom_range(0, 19);
      if (r < 12) seq_key(POOL[$urandom_range(0, 7)], 1'($urandom));
      else if (r < 14) seq_pause();
      else if (r < 15) send($urandom_range(0, 1) ? 8'hFF : 8'h00, 4'h0, 1'b1);
      else if (r < 17) send(ign[$urandom_range(0, 2)], m_held, 1'b0);
      else seq_err($urandom_range(0, 5));
    end
`ifdef PS2_PREFIX_TIMEOUT_EN
    send(8'hE0, m_held, 1'b0);
    tmo_ok = 1'b1;
    repeat (150010) tick();
    tmo_ok = 1'b0;
    tmo_done = 1'b1;
    tick();
    tmo_done = 1'b0;
    seq_key(9'h01D, 1'b1);
`endif
    repeat (4) tick();
    fin = 1'b1;
    tick();
    fin = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
